// File: rtl/matrix_frame_scanner.sv
// Drives two 8x8 LED matrices as one 16x8 playfield, one row per slot with a blanked lead-in.
// Game inputs are captured once per frame so a frame never mixes old and new state.
module matrix_frame_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       FPGA_clk,
    input  logic       reset,
    input  logic [1:0] gamestate,
    input  logic [3:0] x,
    input  logic [2:0] y,
    input  logic [7:0] my_plate,
    input  logic [7:0] enemy_plate,
    output logic [7:0] dot_row,
    output logic [7:0] dot0_col,
    output logic [7:0] dot1_col,
    output logic       frame_start
);

    localparam int DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        GS_COUNTDOWN = 2'd0,
        GS_PLAY      = 2'd1,
        GS_OVER      = 2'd2,
        GS_GOAL      = 2'd3
    } gs_t;

    logic [DIV_W-1:0]   r_div;
    logic [2:0]         r_row;
    logic [BLINK_W-1:0] r_blink;
    logic               r_dark;
    gs_t                r_gs;
    logic [3:0]         r_x;
    logic [2:0]         r_y;
    logic [7:0]         r_my;
    logic [7:0]         r_enemy;
    logic [7:0]         r_dot_row;
    logic [7:0]         r_dot0;
    logic [7:0]         r_dot1;
    logic               r_frame_start;

    logic               w_tick;
    logic               w_wrap;
    logic [DIV_W-1:0]   w_div_next;
    logic [2:0]         w_row_next;
    logic [BLINK_W-1:0] w_blink_next;
    logic               w_dark_next;
    gs_t                w_gs_next;
    logic [3:0]         w_x_next;
    logic [2:0]         w_y_next;
    logic [7:0]         w_my_next;
    logic [7:0]         w_enemy_next;
    logic [7:0]         w_plate0;
    logic [7:0]         w_plate1;
    logic [7:0]         w_ball0;
    logic [7:0]         w_ball1;
    logic [7:0]         w_col0_next;
    logic [7:0]         w_col1_next;
    logic [7:0]         w_row_sel_next;
    logic               w_blank_next;

    // Outputs are built from next-state values so the registered LEDs line up with
    // the divider/row they belong to rather than lagging one cycle behind.
    always_comb begin
        w_tick     = (r_div == DIV_W'(SCAN_DIV - 1));
        w_wrap     = w_tick && (r_row == 3'd7);
        w_div_next = w_tick ? '0 : r_div + 1'b1;
        w_row_next = w_tick ? r_row + 3'd1 : r_row;

        w_gs_next    = w_wrap ? gs_t'(gamestate) : r_gs;
        w_x_next     = w_wrap ? x           : r_x;
        w_y_next     = w_wrap ? y           : r_y;
        w_my_next    = w_wrap ? my_plate    : r_my;
        w_enemy_next = w_wrap ? enemy_plate : r_enemy;

        w_blink_next = r_blink;
        w_dark_next  = r_dark;
        if (w_wrap) begin
            if (r_blink == BLINK_W'(BLINK_FRAMES - 1)) begin
                w_blink_next = '0;
                w_dark_next  = ~r_dark;
            end else begin
                w_blink_next = r_blink + 1'b1;
            end
        end

        w_plate0 = {7'b0, w_enemy_next[w_row_next]};
        w_plate1 = {w_my_next[w_row_next], 7'b0};
        w_ball0  = 8'h00;
        w_ball1  = 8'h00;
        if (w_y_next == w_row_next) begin
            if (w_x_next[3]) w_ball1 = 8'b1 << w_x_next[2:0];
            else             w_ball0 = 8'b1 << w_x_next[2:0];
        end

        case (w_gs_next)
            GS_COUNTDOWN: begin
                w_col0_next = w_plate0;
                w_col1_next = w_plate1;
            end
            GS_PLAY: begin
                w_col0_next = w_plate0 | w_ball0;
                w_col1_next = w_plate1 | w_ball1;
            end
            GS_OVER: begin
                w_col0_next = w_dark_next ? 8'h00 : 8'hFF;
                w_col1_next = w_dark_next ? 8'h00 : 8'hFF;
            end
            default: begin
                w_col0_next = w_plate0 | (w_dark_next ? 8'h00 : w_ball0);
                w_col1_next = w_plate1 | (w_dark_next ? 8'h00 : w_ball1);
            end
        endcase

        w_row_sel_next = 8'b1 << w_row_next;
        w_blank_next   = (w_div_next < DIV_W'(BLANK_CYC));
        if (w_blank_next) begin
            w_row_sel_next = 8'h00;
            w_col0_next    = 8'h00;
            w_col1_next    = 8'h00;
        end
    end

    always_ff @(posedge FPGA_clk or negedge reset) begin
        if (!reset) begin
            r_div         <= '0;
            r_row         <= 3'd0;
            r_blink       <= '0;
            r_dark        <= 1'b0;
            r_gs          <= GS_COUNTDOWN;
            r_x           <= 4'd0;
            r_y           <= 3'd0;
            r_my          <= 8'h00;
            r_enemy       <= 8'h00;
            r_dot_row     <= 8'h00;
            r_dot0        <= 8'h00;
            r_dot1        <= 8'h00;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_next;
            r_row         <= w_row_next;
            r_blink       <= w_blink_next;
            r_dark        <= w_dark_next;
            r_gs          <= w_gs_next;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_my          <= w_my_next;
            r_enemy       <= w_enemy_next;
            r_dot_row     <= w_row_sel_next;
            r_dot0        <= w_col0_next;
            r_dot1        <= w_col1_next;
            r_frame_start <= w_wrap;
        end
    end

    assign dot_row     = r_dot_row;
    assign dot0_col    = r_dot0;
    assign dot1_col    = r_dot1;
    assign frame_start = r_frame_start;

endmodule
